mole_hit_detector: RTL and testbench
====================================

Name: mole_hit_detector

Overview:
- Upstream feeder of the score counter.
- Synchronizes and debounces raw per-hole buttons, then compares each press against the mole-active mask from the mole generator.
- Emits single-cycle hit_pulse / miss_pulse events. hit_pulse drives the score counter's hit_pulse input directly.
- One instance per game; all holes are handled in parallel.

Parameters:
- NUM_HOLES, 4, number of holes/buttons (2..16).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the stable level before it is accepted (1..65535).
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  game running; when 0, press events are discarded.
- clear  in  1  new round; clears per-hole consumed flags.
- btn_raw  in  NUM_HOLES  asynchronous raw buttons, active-high.
- mole_active  in  NUM_HOLES  mole currently up in hole i (synchronous to clk).
- hit_pulse  out  1  one-cycle pulse: valid hit.
- miss_pulse  out  1  one-cycle pulse: press on an empty or already-hit hole.
- hit_index  out  IDX_W  hole index of the last evaluated press; IDX_W = max(1, clog2(NUM_HOLES)).
- btn_level  out  NUM_HOLES  debounced button levels.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: all synchronizer flops, counters, stable levels, consumed flags, hit_pulse, miss_pulse, hit_index and btn_level go to 0. A button held through reset is seen as a fresh press after release of rst.
- Synchronizer: two flops per button (s1, s2).
- Debounce, per hole:
  - If s2 == stable, the counter is 0.
  - Otherwise the counter increments. On the cycle the counter equals DEBOUNCE_CYCLES-1, stable takes s2 at the next edge and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Press event: stable rising edge (stable=1, stable_d=0), decoded combinationally. Falling edges generate nothing.
- Latency: with btn_raw first sampled high at edge N, stable rises at edge N+1+DEBOUNCE_CYCLES and the pulse is registered at edge N+2+DEBOUNCE_CYCLES. Total is DEBOUNCE_CYCLES+3 edges (7 for D=4).
- Arbitration: if several press events occur in one cycle, only the lowest index is evaluated. The others are dropped, not queued.
- Evaluation of selected press i, when enable=1 and clear=0:
  - mole_active[i]=1 and consumed[i]=0: hit_pulse=1, consumed[i] set.
  - Otherwise: miss_pulse=1.
  - hit_index=i in both cases. hit_index holds its value between events.
- hit_pulse and miss_pulse are never high together. Each lasts exactly one cycle.
- Consumed flag i is cleared whenever mole_active[i]=0, so each mole pop scores at most once.
- Same-cycle mole drop: a press in the same cycle that mole_active[i] falls uses the sampled value 0, giving a miss.
- enable=0: press events are discarded, with no pulses and no consumed change. Debouncers and btn_level keep running.
- clear=1: all consumed flags go to 0 and pulses are suppressed that cycle. clear takes priority over a simultaneous press.
- Held button: one pulse per press; no auto-repeat.

Decomposition:
- Shared package game_pkg:
  - NUM_HOLES default.
  - Function idx_width(n) = max(1, clog2(n)).
  - DEBOUNCE_CYCLES default, shared with the mole generator and top level.
- Sub-module button_debouncer (parameters DEBOUNCE_CYCLES, CNT_W; ports clk, rst, raw, level). It contains the synchronizer, counter and stable flop, and is instantiated NUM_HOLES times via generate.
- Arbitration, consumed flags and output registers live in mole_hit_detector.

Test Plan (NUM_HOLES=4, DEBOUNCE_CYCLES=4):
- Reset and debounce:
  - Hold rst=1 for 3 cycles → all outputs 0.
  - Pulse btn_raw[2] high for 3 cycles only → btn_level stays 0x0, no pulses.
- Valid hit: mole_active=0b0100, enable=1, btn_raw[2] raised and held → hit_pulse high for exactly 1 cycle, 7 edges after first sampling; hit_index=2; miss_pulse=0.
- Double hit / empty hole:
  - Release btn_raw[2] and press it again while mole_active[2] is still 1 → miss_pulse once (hole consumed).
  - Drop mole_active[2] to 0, raise it to 1, press again → hit_pulse.
  - Press btn_raw[0] with mole_active[0]=0 → miss_pulse, hit_index=0.
- Simultaneous presses: btn_raw=0b1010 rising in the same cycle with mole_active=0b1010 → exactly one hit_pulse with hit_index=1. Hole 3 is dropped: no second pulse, consumed[3] stays 0.
- Enable/clear:
  - enable=0 during a valid press → no pulses, btn_level[i] still goes to 1.
  - clear=1 in the same cycle as a press event → no pulse, consumed flags all 0.
- Integration: chain with score_counter (MAX_SCORE=99), 10 valid hits → score=10; 3 misses → score still 10.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and helpers used by the mole generator, hit detector and top level.
package game_pkg;

  localparam int NUM_HOLES       = 4;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_HIT  = 2'd1,
    EV_MISS = 2'd2
  } press_ev_t;

  // Index width for n holes; a single hole still needs one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counter-based debouncer for one raw button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic             s1, s2, stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any return to the stable level restarts the count, so short glitches die here.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/mole_hit_detector.sv
// Debounces per-hole buttons and scores each press against the mole-active mask,
// emitting single-cycle hit/miss events for the score counter.
module mole_hit_detector
  import game_pkg::*;
#(
  parameter int NUM_HOLES       = game_pkg::NUM_HOLES,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [NUM_HOLES-1:0]              btn_raw,
  input  logic [NUM_HOLES-1:0]              mole_active,
  output logic                              hit_pulse,
  output logic                              miss_pulse,
  output logic [idx_width(NUM_HOLES)-1:0]   hit_index,
  output logic [NUM_HOLES-1:0]              btn_level
);

  localparam int IDX_W = idx_width(NUM_HOLES);

  logic [NUM_HOLES-1:0] level, level_d, press;
  logic [NUM_HOLES-1:0] consumed, consumed_nxt;
  logic                 sel_vld;
  logic [IDX_W-1:0]     sel_idx;
  press_ev_t            ev;

  genvar g;
  generate
    for (g = 0; g < NUM_HOLES; g++) begin : g_hole
      button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[g]),
        .level (level[g])
      );
    end
  endgenerate

  assign press     = level & ~level_d;
  assign btn_level = level;

  // Lowest-index press wins; simultaneous presses on higher holes are dropped.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (press[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ev           = EV_NONE;
    consumed_nxt = consumed & mole_active;
    if (clear) begin
      consumed_nxt = '0;
    end else if (enable && sel_vld) begin
      if (mole_active[sel_idx] && !consumed[sel_idx]) begin
        ev                    = EV_HIT;
        consumed_nxt[sel_idx] = 1'b1;
      end else begin
        ev = EV_MISS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d    <= '0;
      consumed   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hit_index  <= '0;
    end else begin
      level_d    <= level;
      consumed   <= consumed_nxt;
      hit_pulse  <= (ev == EV_HIT);
      miss_pulse <= (ev == EV_MISS);
      if (ev != EV_NONE) hit_index <= sel_idx;
    end
  end

endmodule

// File: tb/tb_mole_hit_detector.sv
// Scoreboard bench: expected hit/miss events are queued with their due cycle when a press is driven.
module tb_mole_hit_detector;

  localparam int NH = 4;
  localparam int DC = 4;
  localparam int LAT = DC + 3;

  logic          clk = 1'b0;
  logic          rst, enable, clear;
  logic [NH-1:0] btn_raw, mole_active;
  logic          hit_pulse, miss_pulse;
  logic [1:0]    hit_index;
  logic [NH-1:0] btn_level;

  typedef struct {
    int kind;  // 1 = hit, 2 = miss
    int idx;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   score = 0;

  mole_hit_detector #(.NUM_HOLES(NH), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear       (clear),
    .btn_raw     (btn_raw),
    .mole_active (mole_active),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .hit_index   (hit_index),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every observed event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (hit_pulse || miss_pulse)) begin
      chk("excl", 32'(hit_pulse & miss_pulse), 32'd0);
      if (hit_pulse && score < 99) score <= score + 1;
      if (exp_q.size() == 0) begin
        chk("spurious", {30'd0, miss_pulse, hit_pulse}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("kind", hit_pulse ? 32'd1 : 32'd2, 32'(e.kind));
        chk("idx", 32'(hit_index), 32'(e.idx));
        chk("due", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // act: 0 none, 1 clear on the press-event cycle, 2 drop mole on the press-event cycle
  task automatic press(input logic [NH-1:0] mask, input int kind, input int idx, input int act);
    exp_t e;
    btn_raw = mask;
    if (kind != 0) begin
      e.kind = kind; e.idx = idx; e.due = cyc + LAT;
      exp_q.push_back(e);
    end
    tick(DC + 2);
    if (act == 1) clear = 1'b1;
    if (act == 2) mole_active[idx] = 1'b0;
    tick(1);
    clear = 1'b0;
    tick(10);
    btn_raw = '0;
    tick(12);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0; btn_raw = '0; mole_active = '0;
    tick(3);
    chk("rst_hit", 32'(hit_pulse), 32'd0);
    chk("rst_miss", 32'(miss_pulse), 32'd0);
    chk("rst_idx", 32'(hit_index), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    rst = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window
    btn_raw = 4'b0100;
    tick(3);
    btn_raw = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_level", 32'(btn_level), 32'd0);
    end

    // Hit, repeat on a consumed hole, re-pop, empty hole
    mole_active = 4'b0100;
    press(4'b0100, 1, 2, 0);
    press(4'b0100, 2, 2, 0);
    mole_active = 4'b0000; tick(1);
    mole_active = 4'b0100; tick(1);
    press(4'b0100, 1, 2, 0);
    press(4'b0001, 2, 0, 0);

    // Simultaneous presses: only hole 1 evaluated, hole 3 left unconsumed
    mole_active = 4'b1010;
    press(4'b1010, 1, 1, 0);
    press(4'b1000, 1, 3, 0);

    // Disabled: no events but debounced level still follows
    enable = 1'b0;
    btn_raw = 4'b0010;
    tick(DC + 4);
    chk("dis_level", 32'(btn_level), 32'h2);
    btn_raw = '0;
    tick(12);
    enable = 1'b1;

    // Clear on the press cycle suppresses it and frees all consumed holes
    press(4'b0010, 0, 1, 1);
    press(4'b0010, 1, 1, 0);
    press(4'b1000, 1, 3, 0);

    // Mole dropping on the press cycle counts as a miss
    mole_active = 4'b0001;
    tick(1);
    press(4'b0001, 2, 0, 2);

    // Score chain: 10 hits then 3 misses
    score = 0;
    for (int k = 0; k < 10; k++) begin
      mole_active = 4'b0000; tick(1);
      mole_active = 4'b0100; tick(1);
      press(4'b0100, 1, 2, 0);
    end
    for (int k = 0; k < 3; k++) press(4'b0001, 2, 0, 0);
    chk("score", 32'(score), 32'd10);

    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
